// File: rtl/riscv_pkg.sv
// Shared core constants and types for the FP write-back path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int FpWidth        = 32;
  localparam int FpRegAddrWidth = 5;

  // Producers competing for the FP register file write port
  localparam int NumFpWbSrc     = 3;
  localparam int FpWbSrcLoad    = 0;
  localparam int FpWbSrcFpu     = 1;
  localparam int FpWbSrcDivSqrt = 2;

  // One producer's offer toward the FP write-back arbiter
  typedef struct packed {
    logic                      valid;
    logic [FpRegAddrWidth-1:0] dest_reg;
    logic [FpWidth-1:0]        data;
  } fp_wb_req_t;

endpackage

// File: rtl/fp_wb_pick.sv
// Rotating priority picker: first set request at or after 'start', wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own accept.
// Ports: req (request vector), start (highest-priority index, must be < N),
//        grant (one-hot or zero), any (some request was granted).
module fp_wb_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic          any
);

  int idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Arbitrates FP result producers onto the single FP regfile write port.
// Latency: 1 cycle from accept to write_enable; one result per unstalled cycle.
// Backpressure: held result freezes while i_stall; o_ready drops only when full and stalled.
// Ports: i_clk, i_rst_n (sync, active-low), i_stall; per-source i_valid/i_dest_reg/i_data
//        (flattened, source k at slice k) with o_ready; registered write port
//        o_fp_regfile_write_enable/o_fp_dest_reg/o_fp_regfile_write_data; o_grant_src.
// Build option: define FP_WB_ARB_ROUND_ROBIN_EN for round-robin, otherwise fixed 0>1>2.
module fp_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_SRC        = NumFpWbSrc,
  parameter int DATA_WIDTH     = FpWidth,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_stall,
  input  logic [NUM_SRC-1:0]                i_valid,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] i_dest_reg,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]     i_data,
  output logic [NUM_SRC-1:0]                o_ready,
  output logic                              o_fp_regfile_write_enable,
  output logic [REG_ADDR_WIDTH-1:0]         o_fp_dest_reg,
  output logic [DATA_WIDTH-1:0]             o_fp_regfile_write_data,
  output logic [$clog2(NUM_SRC)-1:0]        o_grant_src
);

  localparam int SRC_W = $clog2(NUM_SRC);

  logic                      out_valid;
  logic [REG_ADDR_WIDTH-1:0] out_dest;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [SRC_W-1:0]          out_src;

  logic                      can_accept;
  logic                      any_req;
  logic                      xfer;
  logic [NUM_SRC-1:0]        grant;
  logic [SRC_W-1:0]          start;
  logic [SRC_W-1:0]          grant_idx;
  logic [REG_ADDR_WIDTH-1:0] sel_dest;
  logic [DATA_WIDTH-1:0]     sel_data;

  // The register may take a new result if it is empty or will drain this cycle.
  // An empty register accepts even under stall and simply holds the result.
  assign can_accept = ~out_valid | ~i_stall;

  fp_wb_pick #(
    .N  (NUM_SRC),
    .IW (SRC_W)
  ) u_pick (
    .req   (i_valid),
    .start (start),
    .grant (grant),
    .any   (any_req)
  );

  assign o_ready = can_accept ? grant : '0;
  assign xfer    = any_req & can_accept;

  // One-hot grant to index and muxed payload
  always_comb begin
    grant_idx = '0;
    sel_dest  = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant[k]) begin
        grant_idx = SRC_W'(k);
        sel_dest  = i_dest_reg[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        sel_data  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef FP_WB_ARB_ROUND_ROBIN_EN
  // Pointer names the highest-priority source; it moves just past the winner.
  logic [SRC_W-1:0] rr_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_valid <= 1'b0;
      out_dest  <= '0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_dest  <= sel_dest;
      out_data  <= sel_data;
      out_src   <= grant_idx;
    end else if (can_accept) begin
      // Drained (or already empty) with nothing new to load
      out_valid <= 1'b0;
    end
  end

  assign o_fp_regfile_write_enable = out_valid;
  assign o_fp_dest_reg             = out_dest;
  assign o_fp_regfile_write_data   = out_data;
  assign o_grant_src               = out_src;

endmodule

// File: doc/fp_wb_arbiter.md
# fp_wb_arbiter

Shares the single FP register file write port among the FP result producers: FP load return, the pipelined FPU (add/mul/FMA/convert), and the iterative FP div/sqrt unit. Each producer offers a `(dest_reg, data)` result over a valid/ready handshake. The arbiter grants one producer per cycle into a one-entry output register. That register drives `fp_regfile_write_enable`, `fp_dest_reg` and `fp_regfile_write_data` toward the WB stage, and also serves as a forwarding source. It sits between the FP completion units and the MA→WB boundary, and it honours pipeline stall.

## Interface
Parameters:
- NUM_SRC, 3, number of requesting producers (index 0 = FP load, 1 = pipelined FPU, 2 = div/sqrt)
- DATA_WIDTH, riscv_pkg::FpWidth, result width
- REG_ADDR_WIDTH, 5, FP register address width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low
- i_stall  in  1  pipeline stall (i_pipeline_ctrl.stall)
- i_valid  in  NUM_SRC  per-source result valid
- i_dest_reg  in  NUM_SRC×REG_ADDR_WIDTH  per-source destination FP register
- i_data  in  NUM_SRC×DATA_WIDTH  per-source result data
- o_ready  out  NUM_SRC  per-source accept; one-hot or zero
- o_fp_regfile_write_enable  out  1  output register valid
- o_fp_dest_reg  out  REG_ADDR_WIDTH  write address
- o_fp_regfile_write_data  out  DATA_WIDTH  write data
- o_grant_src  out  $clog2(NUM_SRC)  source index of the held result (debug/perf)

## Operation
- Output register state: out_valid, out_dest, out_data, out_src.
- Accept condition: can_accept = ~out_valid | ~i_stall.
- Grant:
  - Pick one valid source per the arbitration policy.
  - Assert o_ready for that source only, when can_accept is high.
  - A transfer occurs when i_valid[k] & o_ready[k].
- On a transfer:
  - Load out_dest, out_data and out_src from source k.
  - Set out_valid = 1.
- No transfer while can_accept is high: out_valid clears to 0.
- i_stall = 1 with out_valid = 1:
  - Hold all output state.
  - Drive o_ready = 0 for all sources.
- i_stall = 1 with out_valid = 0: an accept is still allowed. The result waits in the register until the stall drops.
- Producers:
  - Must hold valid, dest and data stable until ready.
  - May not withdraw a pending request.
- Ordering:
  - In-order within a source.
  - No ordering across sources. WAW between producers is prevented upstream by the FP scoreboard and is not checked here.
- o_ready is combinational from i_valid, i_stall and internal state. It must not feed back into i_valid within the same cycle.

## Timing
- Reset (i_rst_n = 0 at the edge) clears:
  - out_valid = 0, out_dest = 0, out_data = 0, out_src = 0.
  - Round-robin pointer = 0.
- Outputs are 0 after reset. o_ready = 0 whenever no source is valid.
- Latency: a transfer in cycle N gives o_fp_regfile_write_enable = 1 in cycle N+1. The regfile write takes effect at the end of the first cycle ≥ N+1 with i_stall = 0.
- Throughput: one result per unstalled cycle; back-to-back transfers do not add bubbles.
- Simultaneous requests: exactly one grant. Losers keep valid asserted and are served later.
- Reset mid-operation: a held result is discarded and not written. Producers are re-initialised by the same reset.

## Configuration
- FP_WB_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration.
  - The pointer holds the highest-priority index.
  - After a transfer from source k, the pointer becomes (k+1) mod NUM_SRC. With NUM_SRC = 3 this is a wrap from 2 to 0.
  - The pointer does not change when no transfer occurs.
- FP_WB_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: source 0 > 1 > 2.
  - No pointer register exists.

## Structure
- riscv_pkg additions:
  - NumFpWbSrc constant.
  - Source index localparams: FpWbSrcLoad, FpWbSrcFpu, FpWbSrcDivSqrt.
  - fp_wb_req_t struct (valid, dest_reg, data).
- One sub-module, fp_wb_pick: a combinational priority picker. It takes a request vector and a start index, and outputs a one-hot grant plus an any-grant flag. Fixed-priority mode ties the start index to 0.

## Test plan
- Single request: src1 valid, dest=5, data=0x3F800000, no stall → o_ready[1] = 1 in that cycle. Next cycle: write_enable = 1, dest = 5, data = 0x3F800000, grant_src = 1.
- Contention, fixed priority (macro undefined): src0 and src2 valid continuously for 2 cycles → src0 granted in cycle 0. Src2 is granted in cycle 1 only if src0 drops valid.
- Round-robin (macro defined): all 3 sources valid for 6 cycles → grant order 0, 1, 2, 0, 1, 2. Pointer wraps from 2 to 0.
- Stall hold: result for dest=7 in the output register, i_stall = 1 for 3 cycles with src0 valid → outputs held and o_ready = 0 throughout. When the stall drops: src0 is accepted that cycle, and dest=7 is written at that edge.
- Stall with empty register: i_stall = 1, out_valid = 0, src2 valid with dest=31 → accepted. write_enable = 1 with dest = 31 is held until the stall drops.
- Reset mid-operation: out_valid = 1, then i_rst_n = 0 for 1 cycle → all outputs 0 at the next cycle and pointer = 0. Src2 then gets no preference over src0.
